// File: rtl/gray_monitor.sv
// Checks a 3-bit Gray counter stream: decodes to binary, verifies single-step
// increments, extends into a wide count and latches sticky protocol errors.
module gray_monitor #(
   parameter int WRAP_W = 8
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              Clear,
   input  logic              Valid,
   input  logic [2:0]        Gray,
   input  logic              OvfIn,
   output logic [2:0]        Bin,
   output logic [WRAP_W+2:0] Count,
   output logic              Wrap,
   output logic              Locked,
   output logic              Error,
   output logic [1:0]        ErrCode
);

   localparam int CW = WRAP_W + 3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_TRACK,
      ST_ERROR
   } state_t;

   state_t          state;
   state_t          next_state;
   logic [2:0]      bin_code;
   logic [2:0]      delta;
   logic            step_err;
   logic            ovf_drop;
   logic            ovf_prev;
   logic            ovf_prev_nxt;
   logic [2:0]      bin_nxt;
   logic [CW-1:0]   count_nxt;
   logic            wrap_nxt;
   logic            error_nxt;
   logic [1:0]      errcode_nxt;

   assign bin_code = {Gray[2], Gray[2] ^ Gray[1], Gray[2] ^ Gray[1] ^ Gray[0]};
   assign delta    = bin_code - Bin;
   assign step_err = (delta != 3'd0) && (delta != 3'd1);
   assign ovf_drop = ovf_prev & ~OvfIn;
   assign Locked   = (state == ST_TRACK);

   // Clear wins over everything; a step error outranks an overflow drop
   always_comb begin
      next_state   = state;
      bin_nxt      = Bin;
      count_nxt    = Count;
      wrap_nxt     = 1'b0;
      error_nxt    = Error;
      errcode_nxt  = ErrCode;
      ovf_prev_nxt = ovf_prev;
      if (Clear) begin
         next_state   = ST_IDLE;
         bin_nxt      = 3'd0;
         count_nxt    = '0;
         error_nxt    = 1'b0;
         errcode_nxt  = 2'd0;
         ovf_prev_nxt = 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (Valid) begin
                  bin_nxt      = bin_code;
                  count_nxt    = {{WRAP_W{1'b0}}, bin_code};
                  ovf_prev_nxt = OvfIn;
                  next_state   = ST_TRACK;
               end
            end
            ST_TRACK: begin
               if (Valid) begin
                  ovf_prev_nxt = OvfIn;
                  if (step_err) begin
                     error_nxt   = 1'b1;
                     errcode_nxt = (delta == 3'd7) ? 2'd2 : 2'd1;
                     next_state  = ST_ERROR;
                  end else if (ovf_drop) begin
                     error_nxt   = 1'b1;
                     errcode_nxt = 2'd3;
                     next_state  = ST_ERROR;
                  end else if (delta == 3'd1) begin
                     bin_nxt   = bin_code;
                     count_nxt = Count + CW'(1);
                     wrap_nxt  = (Bin == 3'd7);
                  end
               end
            end
            default: begin
               next_state = ST_ERROR;
            end
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state    <= ST_IDLE;
         Bin      <= 3'd0;
         Count    <= '0;
         Wrap     <= 1'b0;
         Error    <= 1'b0;
         ErrCode  <= 2'd0;
         ovf_prev <= 1'b0;
      end else begin
         state    <= next_state;
         Bin      <= bin_nxt;
         Count    <= count_nxt;
         Wrap     <= wrap_nxt;
         Error    <= error_nxt;
         ErrCode  <= errcode_nxt;
         ovf_prev <= ovf_prev_nxt;
      end
   end

endmodule

// File: tb/tb_gray_monitor.sv
// Directed self-checking bench for gray_monitor: a default-width instance and
// a WRAP_W=1 instance share the same stimulus.
module tb_gray_monitor;

   logic        Clk;
   logic        Reset_n;
   logic        Clear;
   logic        Valid;
   logic [2:0]  Gray;
   logic        OvfIn;

   logic [2:0]  Bin;
   logic [10:0] Count;
   logic        Wrap, Locked, Error;
   logic [1:0]  ErrCode;

   logic [2:0]  bin1;
   logic [3:0]  count1;
   logic        wrap1, locked1, error1;
   logic [1:0]  errcode1;

   int checks = 0;
   int errors = 0;

   gray_monitor dut (
      .Clk(Clk), .Reset_n(Reset_n), .Clear(Clear), .Valid(Valid), .Gray(Gray),
      .OvfIn(OvfIn), .Bin(Bin), .Count(Count), .Wrap(Wrap), .Locked(Locked),
      .Error(Error), .ErrCode(ErrCode)
   );

   gray_monitor #(.WRAP_W(1)) dut1 (
      .Clk(Clk), .Reset_n(Reset_n), .Clear(Clear), .Valid(Valid), .Gray(Gray),
      .OvfIn(OvfIn), .Bin(bin1), .Count(count1), .Wrap(wrap1), .Locked(locked1),
      .Error(error1), .ErrCode(errcode1)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // one clock of stimulus, inputs changed on the falling edge, sampled #1 after rising
   task automatic applyStimulus(input logic v, input logic [2:0] g, input logic o,
                                input logic c);
      @(negedge Clk);
      Valid = v;
      Gray  = g;
      OvfIn = o;
      Clear = c;
      @(posedge Clk);
      #1;
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, " bin"},     Bin,     0);
      checkOutput({tag, " count"},   Count,   0);
      checkOutput({tag, " wrap"},    Wrap,    0);
      checkOutput({tag, " locked"},  Locked,  0);
      checkOutput({tag, " error"},   Error,   0);
      checkOutput({tag, " errcode"}, ErrCode, 0);
   endtask

   logic [2:0] seq [9] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111,
                           3'b101, 3'b100, 3'b000};

   initial begin
      Reset_n = 1'b0; Clear = 1'b0; Valid = 1'b0; Gray = 3'b000; OvfIn = 1'b0;
      #12;
      checkIdle("reset");
      @(negedge Clk);
      Reset_n = 1'b1;

      // lock and count through a full cycle
      for (int i = 0; i < 9; i++) begin
         applyStimulus(1'b1, seq[i], 1'b0, 1'b0);
         checkOutput($sformatf("lock bin %0d", i), Bin, i % 8);
         if (i == 0) checkOutput("lock locked", Locked, 1);
         if (i == 7) checkOutput("lock wrap low", Wrap, 0);
      end
      checkOutput("lock count", Count, 8);
      checkOutput("lock count w1", count1, 8);
      checkOutput("lock wrap", Wrap, 1);
      checkOutput("lock error", Error, 0);
      applyStimulus(1'b0, 3'b000, 1'b0, 1'b0);
      checkOutput("wrap one cycle", Wrap, 0);
      checkOutput("idle cycle count", Count, 8);

      // advance to Bin=3 then stall on repeated codes
      applyStimulus(1'b1, 3'b001, 1'b0, 1'b0);
      applyStimulus(1'b1, 3'b011, 1'b0, 1'b0);
      applyStimulus(1'b1, 3'b010, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 3'b010, 1'b0, 1'b0);
      checkOutput("stall bin", Bin, 3);
      checkOutput("stall count", Count, 11);
      checkOutput("stall error", Error, 0);
      checkOutput("stall locked", Locked, 1);

      // skip from Bin=1 to 4
      applyStimulus(1'b0, 3'b000, 1'b0, 1'b1);
      applyStimulus(1'b1, 3'b001, 1'b0, 1'b0);
      checkOutput("skip ref bin", Bin, 1);
      checkOutput("skip ref count", Count, 1);
      applyStimulus(1'b1, 3'b110, 1'b0, 1'b0);
      checkOutput("skip error", Error, 1);
      checkOutput("skip errcode", ErrCode, 1);
      checkOutput("skip locked", Locked, 0);
      checkOutput("skip bin", Bin, 1);
      applyStimulus(1'b1, 3'b011, 1'b0, 1'b0);
      checkOutput("skip ignored bin", Bin, 1);
      checkOutput("skip ignored count", Count, 1);
      checkOutput("skip ignored errcode", ErrCode, 1);

      // backward step with simultaneous overflow drop
      applyStimulus(1'b0, 3'b000, 1'b0, 1'b1);
      applyStimulus(1'b1, 3'b111, 1'b1, 1'b0);
      checkOutput("back ref bin", Bin, 5);
      applyStimulus(1'b1, 3'b110, 1'b0, 1'b0);
      checkOutput("back errcode", ErrCode, 2);
      checkOutput("back error", Error, 1);
      checkOutput("back bin", Bin, 5);

      // overflow drop alone at Count=9
      applyStimulus(1'b0, 3'b000, 1'b0, 1'b1);
      for (int i = 0; i < 9; i++) applyStimulus(1'b1, seq[i], 1'b0, 1'b0);
      checkOutput("ovf pre count", Count, 8);
      applyStimulus(1'b1, 3'b001, 1'b1, 1'b0);
      checkOutput("ovf count9", Count, 9);
      checkOutput("ovf count9 w1", count1, 9);
      applyStimulus(1'b1, 3'b011, 1'b0, 1'b0);
      checkOutput("ovf errcode", ErrCode, 3);
      checkOutput("ovf count frozen", Count, 9);
      checkOutput("ovf bin frozen", Bin, 1);
      checkOutput("ovf locked", Locked, 0);

      // Clear beats a simultaneous Valid, then re-lock
      applyStimulus(1'b1, 3'b011, 1'b0, 1'b1);
      checkIdle("clear");
      applyStimulus(1'b1, 3'b011, 1'b0, 1'b0);
      checkOutput("relock locked", Locked, 1);
      checkOutput("relock bin", Bin, 2);
      checkOutput("relock count", Count, 2);

      // enter ERROR then assert async reset mid-cycle
      applyStimulus(1'b1, 3'b000, 1'b0, 1'b0);
      checkOutput("pre reset errcode", ErrCode, 1);
      applyStimulus(1'b0, 3'b000, 1'b0, 1'b0);
      #2;
      Reset_n = 1'b0;
      #1;
      checkIdle("async reset");
      checkOutput("async reset w1 count", count1, 0);
      @(negedge Clk);
      Reset_n = 1'b1;

      // narrow instance wraps 15 -> 0 with a Wrap pulse
      for (int i = 0; i < 16; i++) begin
         logic [2:0] b;
         b = 3'(i);
         applyStimulus(1'b1, b ^ (b >> 1), 1'b0, 1'b0);
      end
      checkOutput("w1 count15", count1, 15);
      checkOutput("w1 wrap low", wrap1, 0);
      applyStimulus(1'b1, 3'b000, 1'b0, 1'b0);
      checkOutput("w1 count wrap", count1, 0);
      checkOutput("w1 wrap", wrap1, 1);
      checkOutput("w1 error", error1, 0);
      checkOutput("wide count16", Count, 16);
      applyStimulus(1'b0, 3'b000, 1'b0, 1'b0);
      checkOutput("w1 wrap drop", wrap1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout observed running expected finished");
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/gray_monitor.md
# gray_monitor

Downstream checker for the 3-bit Gray-code counter stage. It samples the counter's Gray output and Overflow flag, converts each Gray code to binary, and confirms that every change is a legal single-step increment. It extends the 3-bit value into a wide running count and reports sticky protocol errors, so system-level logic sees a binary count and a health flag.

## Interface
- WRAP_W, 8, width of the wrap-count field; Count is WRAP_W+3 bits
- Clk  in  1  rising-edge clock
- Reset_n  in  1  asynchronous, active-low reset
- Clear  in  1  synchronous clear; returns the block to IDLE
- Valid  in  1  Gray/OvfIn are sampled this cycle (tied to the upstream En)
- Gray  in  3  Gray code from the upstream counter
- OvfIn  in  1  upstream Overflow flag (sticky upstream)
- Bin  out  3  binary value of the last accepted code
- Count  out  WRAP_W+3  extended count, {wraps, Bin}
- Wrap  out  1  one-cycle pulse when a 7→0 step is accepted
- Locked  out  1  high while in TRACK
- Error  out  1  sticky error flag
- ErrCode  out  2  0 none, 1 skip, 2 backward, 3 overflow drop

## Operation
- Conversion: b2=g2; b1=g2^g1; b0=b1^g0.
- States: IDLE, TRACK, ERROR. Reset and Clear both enter IDLE.
- IDLE:
  - Locked=0.
  - On the first Valid, capture Bin=b and Count={0,b}, load OvfPrev=OvfIn, then go to TRACK.
  - The first sample is never checked.
- TRACK:
  - Locked=1.
  - On Valid, compute delta=(b−Bin) mod 8. Register OvfPrev<=OvfIn on every Valid.
  - delta=0: hold. A repeated code is legal and counts as a stall.
  - delta=1: Bin<=b and Count<=Count+1. Count wraps modulo 2^(WRAP_W+3) silently. If the old Bin was 7, pulse Wrap.
  - delta=7: backward error, ErrCode=2.
  - delta 2..6: skip error, ErrCode=1.
  - OvfPrev=1 and OvfIn=0 (upstream overflow dropped without reset): ErrCode=3.
- Error priority, same cycle: a step error (1 or 2) beats an overflow drop (3).
- On any error:
  - Go to ERROR and set Error=1.
  - Freeze Bin and Count; do not pulse Wrap.
- ERROR:
  - Locked=0.
  - Error, ErrCode, Bin and Count are all held.
  - Valid and Gray are ignored. Exit only via Clear or Reset_n.
- Clear:
  - Highest synchronous priority; it wins over Valid in the same cycle.
  - Effect is identical to reset.
- Non-Valid cycles change no state. Wrap deasserts.

## Timing
- Reset values (asynchronous, immediate on Reset_n=0): Bin=0, Count=0, Wrap=0, Locked=0, Error=0, ErrCode=0, OvfPrev=0, state=IDLE.
- All outputs are registered. Results of a Valid sample appear after the same rising edge, i.e. one-cycle latency.
- Locked rises on the edge that accepts the first Valid in IDLE.
- Wrap is high for exactly one cycle, following the edge that accepted 7→0.
- Error and ErrCode update on the edge that samples the offending code. Locked falls on that same edge.
- Reset deassertion mid-stream: the first Valid after release is re-captured as the new reference. No error is raised.
- Back-to-back Valid every cycle is supported with no bubbles.

## Test plan
- Lock and count: Reset_n pulse, then Valid every cycle with Gray 000,001,011,010,110,111,101,100,000.
  - Required: Locked=1 after the 1st edge.
  - Required: Bin tracks 0..7,0 and Count ends at 8.
  - Required: Wrap is high one cycle after the final sample, and Error=0.
- Stall: in TRACK at Bin=3, apply Gray=010 three times.
  - Required: Bin=3 and Count unchanged, Error=0.
- Skip: from Bin=1, apply Gray=110 (b=4).
  - Required: Error=1, ErrCode=1, Locked=0.
  - Required: Bin=1 held and further Valids ignored.
- Backward plus overflow drop together: from Bin=5 with OvfPrev=1, apply Gray=110 (b=4) and OvfIn=0 in the same cycle.
  - Required: ErrCode=2, because the step error has priority.
- Overflow drop alone: at Count=9, apply OvfIn 1 then 0 with legal steps.
  - Required: ErrCode=3 and Count frozen.
  - Then apply Clear with Valid=1 at the same time. Required: IDLE, all outputs 0. The next Valid re-locks.
- Async reset: assert Reset_n=0 mid-cycle while in ERROR.
  - Required: outputs clear immediately, without waiting for a Clk edge.
  - Required: with WRAP_W=1, Count wraps from 15 to 0 while Wrap pulses.
